keypad_scan_ctrl: RTL

Scan controller for a 4x4 matrix keypad. Drives columns one at a time, samples rows, debounces press and release, and emits a one-cycle key pulse plus key code. The pulse feeds the key-press counter's increment input; the code and valid flag are read by the bus-side keyboard register for the LCD demo.

---
 rtl/keypad_scan_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with press/release debounce; optional auto-repeat under KEYPAD_REPEAT_EN
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_DLY   = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_pluse_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o
);

    localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        state_q, state_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [1:0]        cand_col_q, cand_col_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              pulse_q, pulse_d;
    logic              valid_q, valid_d;

    logic [3:0]        rows_s;
    logic              tick;
    logic [1:0]        sel_row;
    logic              cand_bit;
    logic [DEB_W-1:0]  deb_inc;
    logic              accept;
    logic              rep_fire;

    assign rows_s   = sync2_q;
    assign tick     = (slot_cnt_q == SLOT_LAST);
    assign cand_bit = rows_s[cand_row_q];
    assign deb_inc  = deb_cnt_q + DEB_ONE;

    assign col_o       = ~(4'b0001 << col_idx_q);
    assign key_pluse_o = pulse_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = valid_q;

    // Two-flop synchroniser for the asynchronous row lines.
    always_comb begin
        sync1_d = row_i;
        sync2_d = sync1_q;
    end

    // Slot counter: tick marks the last cycle of each column slot.
    always_comb begin
        slot_cnt_d = tick ? '0 : slot_cnt_q + SLOT_W'(1);
    end

    // Lowest-numbered low row wins when several rows are pulled down.
    always_comb begin
        sel_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) begin
                sel_row = i[1:0];
            end
        end
    end

    // Scan/debounce state machine; every decision is taken on tick only.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        deb_cnt_d  = deb_cnt_q;
        key_code_d = key_code_q;
        valid_d    = valid_q;
        accept     = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (rows_s != 4'hF) begin
                        cand_row_d = sel_row;
                        cand_col_d = col_idx_q;
                        deb_cnt_d  = DEB_ONE;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cand_bit) begin
                        if (deb_inc == DEB_DONE) begin
                            accept     = 1'b1;
                            key_code_d = {cand_row_q, cand_col_q};
                            valid_d    = 1'b1;
                            deb_cnt_d  = '0;
                            state_d    = ST_HOLD;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        // Bounce before acceptance: drop the candidate and keep scanning.
                        deb_cnt_d = '0;
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (cand_bit) begin
                        deb_cnt_d = DEB_ONE;
                        state_d   = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (cand_bit) begin
                        if (deb_inc == DEB_DONE) begin
                            valid_d   = 1'b0;
                            deb_cnt_d = '0;
                            state_d   = ST_SCAN;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        // Release bounce: back to holding, no new pulse.
                        deb_cnt_d = '0;
                        state_d   = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // Pulse is registered, so it appears the cycle after the deciding tick.
    always_comb begin
        pulse_d = accept | rep_fire;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY + 1);
    localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DLY);
    // Requires REPEAT_RATE <= REPEAT_DLY: after a repeat the counter restarts
    // REPEAT_RATE ticks short of REP_FIRST.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DLY - REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;

    assign rep_inc = rep_cnt_q + REP_W'(1);

    // Count held ticks; cleared only once the key is fully released back to SCAN.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        if (state_q == ST_SCAN) begin
            rep_cnt_d = '0;
        end else if (tick && (state_q == ST_HOLD) && !cand_bit) begin
            if (rep_inc == REP_FIRST) begin
                rep_fire  = 1'b1;
                rep_cnt_d = REP_RELOAD;
            end else begin
                rep_cnt_d = rep_inc;
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    logic [31:0] repeat_cfg_unused;

    assign rep_fire          = 1'b0;
    assign repeat_cfg_unused = 32'(REPEAT_DLY + REPEAT_RATE);
`endif

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            slot_cnt_q <= '0;
            col_idx_q  <= 2'd0;
            state_q    <= ST_SCAN;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            deb_cnt_q  <= '0;
            key_code_q <= 4'd0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            slot_cnt_q <= slot_cnt_d;
            col_idx_q  <= col_idx_d;
            state_q    <= state_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            deb_cnt_q  <= deb_cnt_d;
            key_code_q <= key_code_d;
            pulse_q    <= pulse_d;
            valid_q    <= valid_d;
        end
    end

endmodule
